restoring_divider: RTL and testbench

Sequential unsigned integer divider built on repeated ripple-carry subtraction, producing one quotient bit per clock. It is the inverse-direction counterpart to the team's ripple-carry adder: the add path becomes a (WIDTH+1)-bit subtract-and-restore path inside a small control FSM. It sits behind switch/key inputs on the lab board, with results driven to LEDs/HEX displays. A start/busy/done handshake makes it reusable by later datapath labs.

---
 rtl/restoring_divider.sv | 151 +++++++++++++++
 tb/tb_restoring_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider.
// One quotient bit is resolved per clock. Each step shifts the partial
// remainder left, trial-subtracts the divisor through a ripple-carry chain
// and keeps the difference only when it is non-negative. The result registers
// update only on entry to DONE, so the LEDs/HEX displays never show working
// values.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

  logic [1:0]       state_reg, state_next;
  // The partial remainder is always below the divisor between steps, so its
  // top bit is zero. Only the low WIDTH bits are stored; the extra bit exists
  // only in the shifted value and in the trial difference.
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  // Datapath for one iteration
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   d_inv;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   carry;
  logic             fits;
  logic [WIDTH-1:0] r_iter;
  logic [WIDTH-1:0] q_iter;
  logic [CW-1:0]    cnt_inc;

  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign d_inv   = ~{1'b0, d_reg};
  assign carry[0] = 1'b1;

  // Ripple subtract: diff = r_shift + ~{0,D} + 1
  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi = gi + 1) begin : g_sub
      assign diff[gi] = r_shift[gi] ^ d_inv[gi] ^ carry[gi];
      if (gi < WIDTH) begin : g_carry
        assign carry[gi+1] = (r_shift[gi] & d_inv[gi]) |
                             (r_shift[gi] & carry[gi]) |
                             (d_inv[gi]   & carry[gi]);
      end
    end
  endgenerate

  // A clear MSB means the divisor fit into the shifted remainder.
  assign fits    = ~diff[WIDTH];
  assign r_iter  = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_iter  = {q_reg[WIDTH-2:0], fits};
  assign cnt_inc = cnt_reg + CW'(1);

  // Next-state and next-value logic for the control FSM and result registers
  always_comb begin
    state_next     = state_reg;
    r_next         = r_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          q_next   = dividend;
          d_next   = divisor;
          r_next   = '0;
          cnt_next = '0;
          if (divisor == '0) begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = S_DONE;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_next   = r_iter;
        q_next   = q_iter;
        cnt_next = cnt_inc;
        if (cnt_inc == LAST_ITER) begin
          quotient_next  = q_iter;
          remainder_next = r_iter;
          dbz_next       = 1'b0;
          state_next     = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and working registers; reset aborts any division in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= S_IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign busy        = (state_reg == S_RUN);
  assign done        = (state_reg == S_DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_q = 4'd0;

  restoring_divider #(.WIDTH(4)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Single division from IDLE with a one-cycle start pulse.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edz);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen = 0;
    dividend = a;
    divisor = b;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) begin
          busy_cnt++;
          chk("hold_q", quotient, prev_q);
        end
        next_cycle();
      end
    end
    chk("done_seen", seen, 1);
    chk("busy_cycles", busy_cnt, edz ? 0 : 4);
    chk("busy_in_done", busy, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d busy_cycles=%0d", a, b,
             quotient, remainder, div_by_zero, busy_cnt);
    prev_q = eq;
    next_cycle();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int dcount;
    int cyc;
    bit seen;
    bit first;
    logic [3:0] eq;
    logic [3:0] er;
    logic [3:0] cap_q;
    logic [3:0] cap_r;

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    Resetn = 1'b1;
    next_cycle();

    run_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_div(4'd5, 4'd7, 4'd0, 4'd5, 1'b0);
    run_div(4'd0, 4'd3, 4'd0, 4'd0, 1'b0);
    run_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    run_div(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

    // Start while busy is ignored
    dividend = 4'd14;
    divisor = 4'd3;
    start = 1'b1;
    next_cycle();
    dividend = 4'd6;
    divisor = 4'd6;
    next_cycle();
    start = 1'b0;
    dcount = 0;
    cap_q = 4'd0;
    cap_r = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dcount++;
        cap_q = quotient;
        cap_r = remainder;
      end
      next_cycle();
    end
    chk("ignore_done_count", dcount, 1);
    chk("ignore_q", cap_q, 4);
    chk("ignore_r", cap_r, 2);
    $display("div 14/3 with 6/6 during busy -> q=%0d r=%0d dones=%0d", cap_q, cap_r, dcount);

    // Asynchronous reset mid-division
    dividend = 4'd11;
    divisor = 4'd2;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    next_cycle();
    Resetn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcount++;
      next_cycle();
    end
    chk("arst_no_done", dcount, 0);
    $display("div 11/2 aborted by reset -> dones=%0d", dcount);
    prev_q = 4'd0;
    run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

    // Exhaustive sweep with start held high
    first = 1;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = 4'(a);
        divisor = 4'(b);
        cyc = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          next_cycle();
          cyc++;
          if (done) seen = 1;
        end
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        chk("sweep_done_seen", seen, 1);
        if (!first) chk("sweep_spacing", cyc, (b == 0) ? 2 : 6);
        chk("sweep_q", quotient, eq);
        chk("sweep_r", remainder, er);
        chk("sweep_dbz", div_by_zero, (b == 0) ? 1 : 0);
        $display("sweep %0d/%0d -> q=%0d r=%0d dbz=%0d spacing=%0d", a, b,
                 quotient, remainder, div_by_zero, cyc);
        first = 0;
        next_cycle();
      end
    end
    start = 1'b0;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
